// File: rtl/async_fifo_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_ctrl_if
// Bundle of the read-side controller's data and handshake signals.
//
// Signals:
//   aempty_n  - asynchronous almost-empty from the comparator (active-low)
//   rptr      - Gray-coded read pointer to the comparator
//   raddr     - binary read address to the memory
//   mem_rdata - memory data at raddr (combinational read)
//   rdata     - output-stage data word
//   rvalid    - rdata holds a valid word
//   rready    - consumer accepts rdata
//   rempty    - read-domain synchronized empty flag
//
// Modports:
//   slave  - the read controller (drives pointer/address/output stage)
//   master - the environment (comparator, memory, consumer)
// -----------------------------------------------------------------------------
interface async_fifo_rd_ctrl_if #(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 8
);
    logic                 aempty_n;
    logic [AddrWidth-1:0] rptr;
    logic [AddrWidth-1:0] raddr;
    logic [DataWidth-1:0] mem_rdata;
    logic [DataWidth-1:0] rdata;
    logic                 rvalid;
    logic                 rready;
    logic                 rempty;

    modport slave (
        input  aempty_n,
        input  mem_rdata,
        input  rready,
        output rptr,
        output raddr,
        output rdata,
        output rvalid,
        output rempty
    );

    modport master (
        output aempty_n,
        output mem_rdata,
        output rready,
        input  rptr,
        input  raddr,
        input  rdata,
        input  rvalid,
        input  rempty
    );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_ctrl
// Read-side controller for the asynchronous-comparison FIFO.
//   - Owns the binary read counter and the registered Gray read pointer that
//     feeds the async comparator.
//   - Synchronizes the comparator's asynchronous almost-empty (aempty_n) into
//     rclk as rempty. Assertion is immediate (async set), deassertion takes
//     two rclk edges (three with the optional extra stage).
//   - One-entry first-word-fall-through output stage with valid/ready.
//
// Optional feature macro: ASYNC_FIFO_RD_SYNC3_EN
//   Defined   : three-flop empty synchronizer (rempty3 -> rempty2 -> rempty).
//   Undefined : two-flop empty synchronizer (rempty2 -> rempty).
//
// Ports:
//   rclk      in   read-domain clock
//   dirclr_n  in   asynchronous active-low reset
//   bus       if   async_fifo_rd_ctrl_if.slave (aempty_n, rptr, raddr,
//                  mem_rdata, rdata, rvalid, rready, rempty)
// -----------------------------------------------------------------------------
module async_fifo_rd_ctrl #(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 8
) (
    input  logic                 rclk,
    input  logic                 dirclr_n,
    async_fifo_rd_ctrl_if.slave  bus
);

    logic [AddrWidth-1:0] r_rbin;
    logic [AddrWidth-1:0] r_rptr;
    logic [DataWidth-1:0] r_rdata;
    logic                 r_rvalid;
    logic                 r_rempty;
    logic                 r_rempty2;

    logic                 w_pop;
    logic [AddrWidth-1:0] w_rbin_next;
    logic [AddrWidth-1:0] w_rgray_next;

    // ------------------------------------------------------------------
    // Empty synchronizer. Both reset and a low aempty_n force every stage
    // to 1 without waiting for a clock, so a freshly emptied FIFO is seen
    // as empty before the next rclk edge. Only the release of empty is
    // pipelined through the flops.
    // ------------------------------------------------------------------
`ifdef ASYNC_FIFO_RD_SYNC3_EN
    logic r_rempty3;

    always_ff @(posedge rclk or negedge dirclr_n or negedge bus.aempty_n) begin
        if (!dirclr_n || !bus.aempty_n) begin
            r_rempty3 <= 1'b1;
            r_rempty2 <= 1'b1;
            r_rempty  <= 1'b1;
        end else begin
            r_rempty3 <= 1'b0;
            r_rempty2 <= r_rempty3;
            r_rempty  <= r_rempty2;
        end
    end
`else
    always_ff @(posedge rclk or negedge dirclr_n or negedge bus.aempty_n) begin
        if (!dirclr_n || !bus.aempty_n) begin
            r_rempty2 <= 1'b1;
            r_rempty  <= 1'b1;
        end else begin
            r_rempty2 <= 1'b0;
            r_rempty  <= r_rempty2;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pop: fetch a new word whenever the FIFO is non-empty and the output
    // stage is either empty or being drained this cycle.
    // ------------------------------------------------------------------
    assign w_pop        = !r_rempty && (!r_rvalid || bus.rready);
    assign w_rbin_next  = r_rbin + AddrWidth'(1);
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

    // Pointer registers. rptr is a flop, not a decode of r_rbin, so the
    // comparator only ever sees single-bit, glitch-free transitions.
    always_ff @(posedge rclk or negedge dirclr_n) begin
        if (!dirclr_n) begin
            r_rbin <= '0;
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rbin <= w_rbin_next;
            r_rptr <= w_rgray_next;
        end
    end

    // Output stage
    always_ff @(posedge rclk or negedge dirclr_n) begin
        if (!dirclr_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else if (w_pop) begin
            r_rdata  <= bus.mem_rdata;
            r_rvalid <= 1'b1;
        end else if (r_rvalid && bus.rready) begin
            // Word consumed with nothing behind it: rdata is left as is.
            r_rvalid <= 1'b0;
        end
    end

    assign bus.rptr   = r_rptr;
    assign bus.raddr  = r_rbin;
    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.rempty = r_rempty;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_rd_ctrl
// Directed, table-driven bench for async_fifo_rd_ctrl (default two-flop
// synchronizer build). Memory holds 0x10+i at address i.
// -----------------------------------------------------------------------------
module tb_async_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic rclk;
    logic dirclr_n;
    logic [DW-1:0] mem [16];

    int checks   = 0;
    int failures = 0;

    async_fifo_rd_ctrl_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    assign bus.mem_rdata = mem[bus.raddr];

    async_fifo_rd_ctrl #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .rclk     (rclk),
        .dirclr_n (dirclr_n),
        .bus      (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        logic          rready;
        logic          aempty_n;
        logic          exp_rempty;
        logic          exp_rvalid;
        logic [DW-1:0] exp_rdata;
        logic [AW-1:0] exp_rptr;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int i);
        bus.rready   = vecs[i].rready;
        bus.aempty_n = vecs[i].aempty_n;
        @(posedge rclk);
        #1;
        $display("vec %0d: rready=%0b aempty_n=%0b -> rempty=%0b rvalid=%0b rdata=%02h rptr=%04b",
                 i, vecs[i].rready, vecs[i].aempty_n, bus.rempty, bus.rvalid, bus.rdata, bus.rptr);
        check($sformatf("vec%0d_rempty", i), 32'(bus.rempty), 32'(vecs[i].exp_rempty));
        check($sformatf("vec%0d_rvalid", i), 32'(bus.rvalid), 32'(vecs[i].exp_rvalid));
        check($sformatf("vec%0d_rdata",  i), 32'(bus.rdata),  32'(vecs[i].exp_rdata));
        check($sformatf("vec%0d_rptr",   i), 32'(bus.rptr),   32'(vecs[i].exp_rptr));
    endtask

    function automatic logic [AW-1:0] gray(input logic [AW-1:0] x);
        return (x >> 1) ^ x;
    endfunction

    initial begin
        logic [AW-1:0] rbin_m;
        logic [AW-1:0] prev_ptr;

        // rready, aempty_n, exp rempty, rvalid, rdata, rptr
        // Release and first word: rempty falls at edge 2, rvalid at edge 3.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 4'b0001};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 4'b0011};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 4'b0010};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 4'b0110};
        // Backpressure: five stalled cycles, word and pointer hold
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 4'b0110};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 4'b0110};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 4'b0110};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 4'b0110};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 4'b0110};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 4'b0111};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h15, 4'b0101};
        // Empty hit (aempty_n dropped mid-cycle before vec 13)
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h15, 4'b0101};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h15, 4'b0101};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h15, 4'b0101};
        // Refill: empty releases after two edges, next word on the third
        vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h15, 4'b0101};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h15, 4'b0101};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h16, 4'b0100};

        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);

        // Reset held for 3 clocks with aempty_n high
        dirclr_n   = 1'b0;
        bus.aempty_n = 1'b1;
        bus.rready   = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        $display("reset: rptr=%04b raddr=%0d rempty=%0b rvalid=%0b rdata=%02h",
                 bus.rptr, bus.raddr, bus.rempty, bus.rvalid, bus.rdata);
        check("reset_rptr",   32'(bus.rptr),   32'd0);
        check("reset_raddr",  32'(bus.raddr),  32'd0);
        check("reset_rempty", 32'(bus.rempty), 32'd1);
        check("reset_rvalid", 32'(bus.rvalid), 32'd0);
        check("reset_rdata",  32'(bus.rdata),  32'd0);
        @(negedge rclk);
        dirclr_n = 1'b1;

        for (int i = 0; i <= 12; i++) apply_vec(i);

        // aempty_n falls mid-cycle: rempty must rise with no clock edge
        bus.aempty_n = 1'b0;
        bus.rready   = 1'b0;
        #1;
        $display("empty hit: rempty=%0b rptr=%04b", bus.rempty, bus.rptr);
        check("empty_async_rempty", 32'(bus.rempty), 32'd1);
        check("empty_async_rptr",   32'(bus.rptr),   32'b0101);

        for (int i = 13; i <= 18; i++) apply_vec(i);

        // Continuous streaming across the pointer wrap
        rbin_m   = 4'd7;
        prev_ptr = bus.rptr;
        bus.rready   = 1'b1;
        bus.aempty_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge rclk);
            #1;
            $display("stream %0d: rdata=%02h rptr=%04b raddr=%0d",
                     k, bus.rdata, bus.rptr, bus.raddr);
            check($sformatf("wrap%0d_rdata", k), 32'(bus.rdata), 32'(8'h10 + rbin_m));
            rbin_m = rbin_m + 4'd1;
            check($sformatf("wrap%0d_rptr",  k), 32'(bus.rptr),  32'(gray(rbin_m)));
            check($sformatf("wrap%0d_raddr", k), 32'(bus.raddr), 32'(rbin_m));
            check($sformatf("wrap%0d_onebit", k), 32'($countones(bus.rptr ^ prev_ptr)), 32'd1);
            prev_ptr = bus.rptr;
        end

        // Reset mid-stream, between edges
        #2;
        dirclr_n = 1'b0;
        #1;
        $display("mid reset: rvalid=%0b rptr=%04b raddr=%0d rempty=%0b",
                 bus.rvalid, bus.rptr, bus.raddr, bus.rempty);
        check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        check("midrst_rptr",   32'(bus.rptr),   32'd0);
        check("midrst_raddr",  32'(bus.raddr),  32'd0);
        check("midrst_rempty", 32'(bus.rempty), 32'd1);
        @(posedge rclk);
        dirclr_n = 1'b1;
        @(posedge rclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
- Read-side controller for the asynchronous-comparison FIFO.
- Owns the Gray-coded read pointer fed to the async comparator, and synchronizes the comparator's asynchronous almost-empty signal (aempty_n) into rclk as rempty.
- Presents a one-entry first-word-fall-through output stage with valid/ready handshake.
- Sits between the dual-port memory read port, the async comparator and the read-domain consumer.

Parameters:
- AddrWidth, 4, pointer and memory address width; depth = 2**AddrWidth. Must match the comparator.
- DataWidth, 8, memory word width.

Ports:
- rclk  input  1  read-domain clock.
- dirclr_n  input  1  reset dirclr_n, asynchronous, active-low.
- aempty_n  input  1  asynchronous almost-empty from the comparator, active-low.
- rptr  output  AddrWidth  Gray-coded read pointer to the comparator.
- raddr  output  AddrWidth  binary read address to the memory.
- mem_rdata  input  DataWidth  memory data at raddr; combinational read.
- rdata  output  DataWidth  output-stage data.
- rvalid  output  1  rdata holds a valid word.
- rready  input  1  consumer accepts rdata.
- rempty  output  1  synchronized empty flag.

Behaviour:
- Reset (dirclr_n low, asynchronous):
  - rbin=0, rptr=0, raddr=0.
  - rempty=1 and internal rempty2=1.
  - rvalid=0, rdata=0.
  - Reset holds while low; it overrides every other event, including a reset mid-transfer.
- Empty synchronizer (two flops, rempty2 -> rempty):
  - aempty_n low sets both flops to 1 immediately, asynchronously. Assertion of empty has zero latency.
  - aempty_n high: each rclk rising edge does rempty2<=0, rempty<=rempty2.
  - Deassertion therefore takes exactly 2 rclk edges after aempty_n rises and stays high.
  - If aempty_n drops during that window, both flops return to 1.
- Pop condition:
  - pop = !rempty && (!rvalid || rready), evaluated at the rclk edge.
  - On pop: rdata<=mem_rdata, rvalid<=1, rbin<=rbin+1 modulo 2**AddrWidth, rptr<=gray(rbin+1) where gray(x)=(x>>1)^x.
  - raddr = rbin, combinational from the register.
- Output stage without a pop:
  - rvalid && rready && rempty: rvalid<=0, rdata held.
  - rvalid && !rready: rdata and rvalid hold. No pop occurs, so there is no overwrite.
- Pointer rules:
  - rptr changes exactly one bit per pop, including the wrap 2**AddrWidth-1 -> 0 (Gray 1000 -> 0000 for AddrWidth=4).
  - rptr is registered and glitch-free; no combinational path from rbin to rptr.
- Last-word handling:
  - The pop that makes rptr equal to the write pointer causes the comparator to drop aempty_n asynchronously, which sets rempty before the next edge.
  - Timing requirement: comparator delay plus rptr clock-to-q must be less than one rclk period.
  - No read of an empty location is permitted.
- Throughput and latency:
  - With rready held at 1 and the FIFO non-empty, one word is delivered per rclk.
  - First-word latency after aempty_n rises: rempty falls at edge 2, rvalid rises at edge 3.
- Reset mid-operation: rvalid drops immediately. The word in the output stage is lost; the pointer returns to 0.

Optional Feature:
- Macro ASYNC_FIFO_RD_SYNC3_EN.
- When defined: a third synchronizer flop is inserted (rempty3 -> rempty2 -> rempty), and all three are set asynchronously by aempty_n low or by reset. Empty-deassert latency becomes 3 rclk edges; first rvalid comes at edge 4.
- When undefined: the two-flop behaviour above applies.
- Assertion behaviour is identical in both cases.

Test Plan:
- Reset: dirclr_n low for 3 rclk with aempty_n=1 -> rptr=0000, raddr=0, rempty=1, rvalid=0; after release, rempty=0 at edge 2 and rvalid=1 at edge 3 with rdata=mem_rdata[0].
- Streaming: rready=1, aempty_n=1, memory preloaded 0x10..0x1F -> rdata 0x10,0x11,... on consecutive edges; rptr sequence 0001,0011,0010,0110,...
- Wrap: 18 pops with AddrWidth=4 -> rptr goes 1000 -> 0000 at pop 16; raddr returns to 0; exactly one rptr bit toggles per pop.
- Backpressure: rready=0 for 5 cycles with rvalid=1, rdata=0x33 -> rdata stays 0x33, rptr unchanged; rready=1 -> the next word appears on the following edge.
- Empty hit: drive aempty_n low mid-cycle after the pop that loads 0x44 -> rempty=1 before the next edge, no further pop, rptr frozen; rvalid falls after 0x44 is accepted.
- Reset mid-stream: dirclr_n pulse low with rvalid=1 and rptr=0110 -> rvalid=0, rptr=0000, rempty=1 immediately, without waiting for an rclk edge.
